// File: rtl/exe_pkg.sv
// Shared encodings and width constants for the execute stage.
package exe_pkg;

    localparam int unsigned CMD_W      = 4;
    localparam int unsigned FLAG_W     = 4;
    localparam int unsigned SHIFT_OP_W = 12;
    localparam int unsigned SIMM_W     = 24;

    // Bit positions inside status_out = {N, Z, C, V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [CMD_W-1:0] {
        CmdMov = 4'b0001,
        CmdAdd = 4'b0010,
        CmdAdc = 4'b0011,
        CmdSub = 4'b0100,
        CmdSbc = 4'b0101,
        CmdAnd = 4'b0110,
        CmdOrr = 4'b0111,
        CmdEor = 4'b1000,
        CmdMvn = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        ShLsl = 2'b00,
        ShLsr = 2'b01,
        ShAsr = 2'b10,
        ShRor = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        FwdReg    = 2'b00,
        FwdMem    = 2'b01,
        FwdWb     = 2'b10,
        FwdRegAlt = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/val2_generator.sv
// Second ALU operand: raw offset for memory ops, rotated imm8, or shifted Rm.
module val2_generator
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  mem_access_i,
    input  logic                  immediate_i,
    input  logic [DATA_W-1:0]     rm_i,
    input  logic [SHIFT_OP_W-1:0] shift_operand_i,
    output logic [DATA_W-1:0]     val2_o
);

    logic [4:0]          rot_amt;
    logic [4:0]          shift_imm;
    logic [DATA_W-1:0]   imm8_ext;
    logic [2*DATA_W-1:0] imm_rot;
    logic [2*DATA_W-1:0] rm_rot;
    logic [DATA_W-1:0]   rm_asr;

    assign rot_amt   = {shift_operand_i[11:8], 1'b0};
    assign shift_imm = shift_operand_i[11:7];
    assign imm8_ext  = DATA_W'(shift_operand_i[7:0]);

    // Rotate right by shifting a doubled copy and keeping the low half
    assign imm_rot = {imm8_ext, imm8_ext} >> rot_amt;
    assign rm_rot  = {rm_i, rm_i} >> shift_imm;
    assign rm_asr  = $signed(rm_i) >>> shift_imm;

    always_comb begin
        val2_o = '0;
        if (mem_access_i) begin
            val2_o = DATA_W'(shift_operand_i);
        end else if (immediate_i) begin
            val2_o = imm_rot[DATA_W-1:0];
        end else begin
            unique case (shift_e'(shift_operand_i[6:5]))
                ShLsl: val2_o = rm_i << shift_imm;
                ShLsr: val2_o = rm_i >> shift_imm;
                ShAsr: val2_o = rm_asr;
                ShRor: val2_o = rm_rot[DATA_W-1:0];
                default: val2_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: ALU, status register, branch target and EX/MEM register.
// Optional operand forwarding is enabled by defining EXE_FORWARDING_EN.
module exe_stage_unit
    import exe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
`ifdef EXE_FORWARDING_EN
    input  logic [1:0]            sel_src1,
    input  logic [1:0]            sel_src2,
    input  logic [DATA_W-1:0]     mem_fwd_value,
    input  logic [DATA_W-1:0]     wb_fwd_value,
`endif
    input  logic [DATA_W-1:0]     PC_in,
    input  logic                  mem_read_en_in,
    input  logic                  mem_write_en_in,
    input  logic                  wb_enable_in,
    input  logic                  immediate_in,
    input  logic                  branch_taken_in,
    input  logic                  status_write_enable_in,
    input  logic [CMD_W-1:0]      execute_command_in,
    input  logic [DATA_W-1:0]     reg_file_in1,
    input  logic [DATA_W-1:0]     reg_file_in2,
    input  logic [REG_ADDR_W-1:0] dest_reg_in,
    input  logic [SIMM_W-1:0]     signed_immediate_in,
    input  logic [SHIFT_OP_W-1:0] shift_operand_in,
    output logic                  branch_taken_out,
    output logic [DATA_W-1:0]     branch_address_out,
    output logic [FLAG_W-1:0]     status_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     st_value_out,
    output logic [REG_ADDR_W-1:0] dest_reg_out,
    output logic                  mem_read_en_out,
    output logic                  mem_write_en_out,
    output logic                  wb_enable_out
);

    logic [DATA_W-1:0]       src1, src2, val2, result, op_b, simm_ext;
    logic [DATA_W:0]         sum;
    logic                    cin, arith, known;
    logic [FLAG_W-1:0]       flags_d, status_q;
    logic [DATA_W-1:0]       result_q, st_value_q;
    logic [REG_ADDR_W-1:0]   dest_q;
    logic                    mem_read_q, mem_write_q, wb_q;

`ifdef EXE_FORWARDING_EN
    always_comb begin
        unique case (fwd_sel_e'(sel_src1))
            FwdMem:  src1 = mem_fwd_value;
            FwdWb:   src1 = wb_fwd_value;
            default: src1 = reg_file_in1;
        endcase
        unique case (fwd_sel_e'(sel_src2))
            FwdMem:  src2 = mem_fwd_value;
            FwdWb:   src2 = wb_fwd_value;
            default: src2 = reg_file_in2;
        endcase
    end
`else
    assign src1 = reg_file_in1;
    assign src2 = reg_file_in2;
`endif

    val2_generator #(
        .DATA_W (DATA_W)
    ) u_val2 (
        .mem_access_i    (mem_read_en_in | mem_write_en_in),
        .immediate_i     (immediate_in),
        .rm_i            (src2),
        .shift_operand_i (shift_operand_in),
        .val2_o          (val2)
    );

    // Subtraction is a + ~b + cin, so C comes out as not-borrow directly
    always_comb begin
        result = '0;
        op_b   = val2;
        cin    = 1'b0;
        arith  = 1'b0;
        known  = 1'b1;
        case (exe_cmd_e'(execute_command_in))
            CmdMov: result = val2;
            CmdMvn: result = ~val2;
            CmdAnd: result = src1 & val2;
            CmdOrr: result = src1 | val2;
            CmdEor: result = src1 ^ val2;
            CmdAdd: arith = 1'b1;
            CmdAdc: begin arith = 1'b1; cin = status_q[FLAG_C]; end
            CmdSub: begin arith = 1'b1; op_b = ~val2; cin = 1'b1; end
            CmdSbc: begin arith = 1'b1; op_b = ~val2; cin = status_q[FLAG_C]; end
            default: known = 1'b0;
        endcase
        sum = {1'b0, src1} + {1'b0, op_b} + (DATA_W+1)'(cin);
        if (arith) begin
            result = sum[DATA_W-1:0];
        end

        flags_d = status_q;
        if (known) begin
            flags_d[FLAG_N] = result[DATA_W-1];
            flags_d[FLAG_Z] = (result == '0);
        end
        if (arith) begin
            flags_d[FLAG_C] = sum[DATA_W];
            flags_d[FLAG_V] = (src1[DATA_W-1] == op_b[DATA_W-1]) &&
                              (result[DATA_W-1] != src1[DATA_W-1]);
        end
    end

    assign simm_ext           = DATA_W'($signed(signed_immediate_in));
    assign branch_address_out = PC_in + (simm_ext << 2);
    assign branch_taken_out   = branch_taken_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= '0;
            result_q    <= '0;
            st_value_q  <= '0;
            dest_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_q        <= 1'b0;
        end else if (!freeze) begin
            if (status_write_enable_in) begin
                status_q <= flags_d;
            end
            result_q    <= result;
            st_value_q  <= src2;
            dest_q      <= dest_reg_in;
            // A taken branch squashes its own side effects in later stages
            mem_read_q  <= mem_read_en_in & ~branch_taken_in;
            mem_write_q <= mem_write_en_in & ~branch_taken_in;
            wb_q        <= wb_enable_in & ~branch_taken_in;
        end
    end

    assign status_out       = status_q;
    assign alu_result_out   = result_q;
    assign st_value_out     = st_value_q;
    assign dest_reg_out     = dest_q;
    assign mem_read_en_out  = mem_read_q;
    assign mem_write_en_out = mem_write_q;
    assign wb_enable_out    = wb_q;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Table-driven scoreboard bench for exe_stage_unit; forwarding checks under EXE_FORWARDING_EN.
module tb_exe_stage_unit;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic [31:0] PC_in;
    logic        mem_read_en_in, mem_write_en_in, wb_enable_in;
    logic        immediate_in, branch_taken_in, status_write_enable_in;
    logic [3:0]  execute_command_in;
    logic [31:0] reg_file_in1, reg_file_in2;
    logic [3:0]  dest_reg_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shift_operand_in;
    logic        branch_taken_out;
    logic [31:0] branch_address_out;
    logic [3:0]  status_out;
    logic [31:0] alu_result_out, st_value_out;
    logic [3:0]  dest_reg_out;
    logic        mem_read_en_out, mem_write_en_out, wb_enable_out;
`ifdef EXE_FORWARDING_EN
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] mem_fwd_value, wb_fwd_value;
`endif

    always #5 clk = ~clk;

    exe_stage_unit #(
        .DATA_W     (32),
        .REG_ADDR_W (4)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .freeze                 (freeze),
`ifdef EXE_FORWARDING_EN
        .sel_src1               (sel_src1),
        .sel_src2               (sel_src2),
        .mem_fwd_value          (mem_fwd_value),
        .wb_fwd_value           (wb_fwd_value),
`endif
        .PC_in                  (PC_in),
        .mem_read_en_in         (mem_read_en_in),
        .mem_write_en_in        (mem_write_en_in),
        .wb_enable_in           (wb_enable_in),
        .immediate_in           (immediate_in),
        .branch_taken_in        (branch_taken_in),
        .status_write_enable_in (status_write_enable_in),
        .execute_command_in     (execute_command_in),
        .reg_file_in1           (reg_file_in1),
        .reg_file_in2           (reg_file_in2),
        .dest_reg_in            (dest_reg_in),
        .signed_immediate_in    (signed_immediate_in),
        .shift_operand_in       (shift_operand_in),
        .branch_taken_out       (branch_taken_out),
        .branch_address_out     (branch_address_out),
        .status_out             (status_out),
        .alu_result_out         (alu_result_out),
        .st_value_out           (st_value_out),
        .dest_reg_out           (dest_reg_out),
        .mem_read_en_out        (mem_read_en_out),
        .mem_write_en_out       (mem_write_en_out),
        .wb_enable_out          (wb_enable_out)
    );

    typedef struct {
        string       name;
        logic [3:0]  cmd;
        logic        imm, mr, mw, wb, s, br;
        logic [31:0] rn, rm;
        logic [11:0] shop;
        logic [3:0]  dest;
        logic [31:0] exp_res;
        logic [3:0]  exp_st;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res, st_val;
        logic [3:0]  status, dest;
        logic [2:0]  ctl;   // {wb, mem_read, mem_write}
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string name, logic [3:0] cmd, logic imm, logic mr, logic mw,
                                logic wb, logic s, logic [31:0] rn, logic [31:0] rm,
                                logic [11:0] shop, logic [3:0] dest, logic [31:0] exp_res,
                                logic [3:0] exp_st);
        vec_t v;
        v.name = name; v.cmd = cmd; v.imm = imm; v.mr = mr; v.mw = mw; v.wb = wb; v.s = s;
        v.br = 1'b0; v.rn = rn; v.rm = rm; v.shop = shop; v.dest = dest;
        v.exp_res = exp_res; v.exp_st = exp_st;
        return v;
    endfunction

    function automatic exp_t expect_of(vec_t v);
        exp_t e;
        e.name   = v.name;
        e.res    = v.exp_res;
        e.status = v.exp_st;
        e.st_val = v.rm;
        e.dest   = v.dest;
        e.ctl    = v.br ? 3'b000 : {v.wb, v.mr, v.mw};
        return e;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_out(exp_t e);
        check({e.name, ".result"}, alu_result_out, e.res);
        check({e.name, ".status"}, 32'(status_out), 32'(e.status));
        check({e.name, ".st_value"}, st_value_out, e.st_val);
        check({e.name, ".dest"}, 32'(dest_reg_out), 32'(e.dest));
        check({e.name, ".ctl"}, 32'({wb_enable_out, mem_read_en_out, mem_write_en_out}),
              32'(e.ctl));
    endtask

    task automatic drive(vec_t v);
        execute_command_in     = v.cmd;
        immediate_in           = v.imm;
        mem_read_en_in         = v.mr;
        mem_write_en_in        = v.mw;
        wb_enable_in           = v.wb;
        status_write_enable_in = v.s;
        branch_taken_in        = v.br;
        reg_file_in1           = v.rn;
        reg_file_in2           = v.rm;
        shift_operand_in       = v.shop;
        dest_reg_in            = v.dest;
    endtask

    // Push expectation, step one edge, pop and compare
    task automatic run_vec(vec_t v);
        exp_t e;
        drive(v);
        sb.push_back(expect_of(v));
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb.pop_front();
            compare_out(e);
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        exp_t hold, zero;
        //          name    cmd     imm mr mw wb s  rn            rm            shop    d  result        st
        vecs[0]  = mk("add_imm", 4'b0010, 1, 0, 0, 1, 0, 32'd5,        32'h0000AAAA, 12'h0FF, 1, 32'h00000104, 4'b0000);
        vecs[1]  = mk("sub_eq",  4'b0100, 0, 0, 0, 1, 1, 32'd3,        32'd3,        12'h000, 2, 32'h00000000, 4'b0110);
        vecs[2]  = mk("adc_c1",  4'b0011, 1, 0, 0, 1, 0, 32'd2,        32'h00000055, 12'h003, 3, 32'h00000006, 4'b0110);
        vecs[3]  = mk("add_wrap",4'b0010, 1, 0, 0, 1, 1, 32'hFFFFFFFF, 32'h00001234, 12'h001, 4, 32'h00000000, 4'b0110);
        vecs[4]  = mk("sbc_c1",  4'b0101, 1, 0, 0, 1, 1, 32'd10,       32'd7,        12'h003, 5, 32'h00000007, 4'b0010);
        vecs[5]  = mk("sub_neg", 4'b0100, 1, 0, 0, 1, 1, 32'd2,        32'd9,        12'h003, 6, 32'hFFFFFFFF, 4'b1000);
        vecs[6]  = mk("sbc_c0",  4'b0101, 1, 0, 0, 1, 1, 32'd10,       32'd1,        12'h003, 7, 32'h00000006, 4'b0010);
        vecs[7]  = mk("mov_rot", 4'b0001, 1, 0, 0, 1, 1, 32'h00000077, 32'd0,        12'h4FF, 8, 32'hFF000000, 4'b1010);
        vecs[8]  = mk("mvn_lsl", 4'b1001, 0, 0, 0, 1, 1, 32'd0,        32'h0000000F, 12'h200, 9, 32'hFFFFFF0F, 4'b1010);
        vecs[9]  = mk("and_lsr", 4'b0110, 0, 0, 0, 1, 0, 32'hFFFF0000, 32'hF0000000, 12'h220, 10, 32'h0F000000, 4'b1010);
        vecs[10] = mk("orr_asr", 4'b0111, 0, 0, 0, 1, 1, 32'h00000001, 32'h80000000, 12'h240, 11, 32'hF8000001, 4'b1010);
        vecs[11] = mk("eor_ror", 4'b1000, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'h0000000F, 12'h260, 12, 32'h0FFFFFFF, 4'b0010);
        vecs[12] = mk("add_ovf", 4'b0010, 1, 0, 0, 1, 1, 32'h7FFFFFFF, 32'd0,        12'h001, 13, 32'h80000000, 4'b1001);
        vecs[13] = mk("bad_cmd", 4'b0000, 0, 0, 0, 1, 1, 32'd5,        32'd3,        12'h000, 14, 32'h00000000, 4'b1001);
        vecs[14] = mk("ld_addr", 4'b0010, 1, 1, 0, 1, 0, 32'h00000100, 32'd0,        12'h4FF, 15, 32'h000005FF, 4'b1001);
        vecs[15] = mk("st_addr", 4'b0010, 0, 0, 1, 0, 0, 32'd4,        32'h00000099, 12'h004, 0, 32'h00000008, 4'b1001);

        zero = '{name: "reset", res: 32'd0, st_val: 32'd0, status: 4'd0, dest: 4'd0, ctl: 3'd0};

`ifdef EXE_FORWARDING_EN
        sel_src1 = 2'b00; sel_src2 = 2'b00; mem_fwd_value = 32'd0; wb_fwd_value = 32'd0;
`endif
        PC_in = 32'd0; signed_immediate_in = 24'd0; freeze = 1'b0;
        drive(vecs[0]);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 compare_out(zero);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i]);
        end

        // Freeze holds everything, including status, while inputs churn
        v = mk("frz_a", 4'b0010, 1, 0, 0, 1, 1, 32'h10, 32'h42, 12'h001, 7, 32'h11, 4'b0000);
        run_vec(v);
        hold = expect_of(v);
        hold.name = "freeze_hold";
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            v = mk("frz_b", 4'b0100, 1, 1, 0, 1, 1, 32'(c), 32'h77 + 32'(c), 12'h001, 4'(c),
                   32'd0, 4'b0000);
            drive(v);
            @(posedge clk); #1;
            compare_out(hold);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        zero.name = "rst_in_freeze";
        compare_out(zero);
        @(negedge clk);
        rst = 1'b0; freeze = 1'b0;

        // Taken branch: combinational target, squashed side effects
        v = mk("br_back", 4'b0010, 1, 1, 0, 1, 0, 32'd1, 32'h33, 12'h001, 5, 32'd2, 4'b0000);
        v.br = 1'b1;
        PC_in = 32'h100; signed_immediate_in = 24'hFFFFFE;
        drive(v);
        #1;
        check("br_back.addr", branch_address_out, 32'h000000F8);
        check("br_back.taken", 32'(branch_taken_out), 32'd1);
        run_vec(v);

        v = mk("br_fwd", 4'b0010, 1, 0, 0, 1, 0, 32'd1, 32'h34, 12'h002, 6, 32'd3, 4'b0000);
        PC_in = 32'h200; signed_immediate_in = 24'h000010;
        drive(v);
        #1;
        check("br_fwd.addr", branch_address_out, 32'h00000240);
        check("br_fwd.taken", 32'(branch_taken_out), 32'd0);
        run_vec(v);

`ifdef EXE_FORWARDING_EN
        sel_src1 = 2'b01; mem_fwd_value = 32'd10;
        sel_src2 = 2'b10; wb_fwd_value = 32'h00005A5A;
        v = mk("fwd_add", 4'b0010, 1, 0, 0, 1, 0, 32'd99, 32'h00005A5A, 12'h001, 9, 32'd11,
               4'b0000);
        run_vec(v);
        sel_src1 = 2'b00; sel_src2 = 2'b00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
